// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory arbiter between fetch and loader
// Loader wins contention until fetch has been denied STARVE_LIMIT cycles in a row.
module imem_arbiter #(
  parameter int RAM_SIZE     = 256,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(RAM_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          stall_if,

  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,

  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       fetch_first;

  assign fetch_first = (starve_cnt == LIMIT);

  // Grants are masked by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    ld_gnt = rst_n & ld_req & ~(if_req & fetch_first);
    if_gnt = rst_n & if_req & ~ld_gnt;
  end

  assign stall_if  = rst_n & if_req & ~if_gnt;
  assign mem_addr  = ld_gnt ? ld_addr : if_addr;
  assign mem_we    = ld_gnt & ld_we;
  assign mem_wdata = ld_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) if_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rvalid <= 1'b0;
      ld_rdata  <= 32'd0;
    end else begin
      ld_rvalid <= ld_gnt & ~ld_we;
      if (ld_gnt && !ld_we) ld_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
// Memory is modelled here as an asynchronous-read, synchronous-write array.
module tb_imem_arbiter;

  localparam int AW = 8;

  logic          clk, rst_n;
  logic          if_req, if_gnt, if_rvalid, stall_if;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata, ld_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  int checks = 0;
  int failures = 0;

  imem_arbiter #(.RAM_SIZE(256), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .stall_if(stall_if),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [3];
  logic        exp_if;

  initial begin
    words[0] = 32'h2008_0005;
    words[1] = 32'h2009_0007;
    words[2] = 32'h0109_5020;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 3; i++) mem[i] = words[i];
    mem[8'h10] = 32'h8C02_0004;

    // Reset with both requesters active: nothing may be granted or written.
    rst_n = 1'b0; if_req = 1'b1; if_addr = 8'd0;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'd7; ld_wdata = 32'h1234_5678;
    #2;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_ld_gnt", 32'(ld_gnt), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_stall", 32'(stall_if), 32'd0);
    tick();
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_ld_rdata", ld_rdata, 32'd0);
    check("rst_no_write", mem[7], 32'd0);
    if_req = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Back-to-back fetches of three words.
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = AW'(i);
      #1;
      check($sformatf("fetch_gnt%0d", i), 32'(if_gnt), 32'd1);
      check($sformatf("fetch_stall%0d", i), 32'(stall_if), 32'd0);
      tick();
      check($sformatf("fetch_rvalid%0d", i), 32'(if_rvalid), 32'd1);
      check($sformatf("fetch_rdata%0d", i), if_rdata, words[i]);
    end
    if_req = 1'b0;
    tick();
    check("fetch_rvalid_drop", 32'(if_rvalid), 32'd0);
    check("fetch_rdata_hold", if_rdata, words[2]);

    // Loader write beats fetch, then the fetch sees the new word.
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'd3; ld_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 8'd3;
    #1;
    check("wr_ld_gnt", 32'(ld_gnt), 32'd1);
    check("wr_if_gnt", 32'(if_gnt), 32'd0);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_stall", 32'(stall_if), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'd3);
    tick();
    ld_req = 1'b0;
    #1;
    check("wr_if_gnt2", 32'(if_gnt), 32'd1);
    check("wr_mem_we2", 32'(mem_we), 32'd0);
    check("wr_no_ld_rvalid", 32'(ld_rvalid), 32'd0);
    check("wr_no_if_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    if_req = 1'b0;
    check("wr_fetch_rvalid", 32'(if_rvalid), 32'd1);
    check("wr_fetch_rdata", if_rdata, 32'hDEAD_BEEF);
    check("wr_ld_rvalid_low", 32'(ld_rvalid), 32'd0);
    tick();

    // Continuous contention: fetch wins on every fifth cycle.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'd5;
    if_req = 1'b1; if_addr = 8'd3;
    for (int c = 1; c <= 10; c++) begin
      exp_if = (c == 5) || (c == 10);
      #1;
      check($sformatf("starve_if_gnt_c%0d", c), 32'(if_gnt), 32'(exp_if));
      check($sformatf("starve_ld_gnt_c%0d", c), 32'(ld_gnt), 32'(!exp_if));
      tick();
    end
    ld_req = 1'b0; if_req = 1'b0;
    tick();

    // Loader reads, back to back; fetch data untouched.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h10;
    #1;
    check("rd_ld_gnt", 32'(ld_gnt), 32'd1);
    check("rd_mem_addr", 32'(mem_addr), 32'h10);
    tick();
    check("rd_ld_rvalid", 32'(ld_rvalid), 32'd1);
    check("rd_ld_rdata", ld_rdata, 32'h8C02_0004);
    check("rd_if_rdata_hold", if_rdata, 32'hDEAD_BEEF);
    ld_addr = 8'd0;
    tick();
    check("rd2_ld_rvalid", 32'(ld_rvalid), 32'd1);
    check("rd2_ld_rdata", ld_rdata, words[0]);
    ld_req = 1'b0;
    tick();
    check("rd_ld_rvalid_drop", 32'(ld_rvalid), 32'd0);
    check("rd_ld_rdata_hold", ld_rdata, words[0]);

    // Build up starvation, then reset mid-response.
    ld_req = 1'b1; if_req = 1'b1; if_addr = 8'd1;
    tick();
    tick();
    ld_req = 1'b0;
    tick();
    check("mid_if_rvalid", 32'(if_rvalid), 32'd1);
    check("mid_if_rdata", if_rdata, words[1]);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(if_rvalid), 32'd0);
    check("mid_rst_rdata", if_rdata, 32'd0);
    check("mid_rst_gnt", 32'(if_gnt), 32'd0);
    check("mid_rst_stall", 32'(stall_if), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_no_resp", 32'(if_rvalid), 32'd0);
    if_req = 1'b1; if_addr = 8'd2;
    #1;
    check("post_rst_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    check("post_rst_rvalid", 32'(if_rvalid), 32'd1);
    check("post_rst_rdata", if_rdata, words[2]);

    // Starvation count must restart from zero after reset: loader wins four times.
    ld_req = 1'b1; ld_addr = 8'd5; if_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("post_rst_starve_if_c%0d", c), 32'(if_gnt), 32'(c == 5));
      tick();
    end
    ld_req = 1'b0; if_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 256, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied fetch cycles before fetch takes priority (legal range 1..15).
REQ-003 SHALL use AW = $clog2(RAM_SIZE) as the width of every address port.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have fetch ports: if_req in 1 fetch request; if_addr in AW word address; if_gnt out 1 fetch granted this cycle; if_rvalid out 1 fetch data valid; if_rdata out 32 fetched word; stall_if out 1 fetch requested but not granted.
REQ-006 SHALL have loader ports: ld_req in 1 loader request; ld_we in 1 1=write, 0=read; ld_addr in AW word address; ld_wdata in 32 write data; ld_gnt out 1 loader granted this cycle; ld_rvalid out 1 loader read data valid; ld_rdata out 32 loader read word.
REQ-007 SHALL have memory ports: mem_addr out AW; mem_we out 1; mem_wdata out 32; mem_rdata in 32, which is combinational (asynchronous-read) from mem_addr.

Function
REQ-008 SHALL assert at most one of if_gnt and ld_gnt in any cycle.
REQ-009 SHALL assert a grant only to an active requester; grants are combinational from current requests and registered starvation state.
REQ-010 SHALL give the loader priority when both request, unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.
REQ-011 SHALL keep a 4-bit saturating starve_cnt: +1 on each cycle if_req=1 and if_gnt=0; cleared to 0 on any cycle with if_gnt=1 or if_req=0; saturates at STARVE_LIMIT.
REQ-012 SHALL drive stall_if = if_req & ~if_gnt.
REQ-013 SHALL drive mem_addr = ld_addr when ld_gnt=1, otherwise if_addr (including when no grant).
REQ-014 SHALL drive mem_we = ld_gnt & ld_we; mem_wdata = ld_wdata at all times.
REQ-015 SHALL, on a granted fetch, register mem_rdata into if_rdata at the same rising edge and assert if_rvalid for exactly the following cycle (latency 1).
REQ-016 SHALL, on a granted loader read (ld_we=0), register mem_rdata into ld_rdata and assert ld_rvalid for exactly the following cycle; a granted write SHALL NOT assert ld_rvalid.
REQ-017 SHALL hold if_rdata and ld_rdata at their last captured values when not updated.
REQ-018 SHALL support back-to-back grants to the same requester every cycle, with rvalid remaining high continuously.
REQ-019 SHALL not forward write data: a fetch of the address written in the same cycle is impossible (single grant); a fetch one cycle after a write SHALL return the newly written word.
REQ-020 SHALL treat requests as single-cycle: a denied requester SHALL hold its request, and the block SHALL NOT queue it.

Reset
REQ-021 SHALL, while rst_n=0, force asynchronously: starve_cnt=0, if_rvalid=0, ld_rvalid=0, if_rdata=0, ld_rdata=0.
REQ-022 SHALL, during reset, keep mem_we=0, if_gnt=0, ld_gnt=0, stall_if=0, regardless of requests.
REQ-023 SHALL, if rst_n falls while an rvalid is pending, drop that rvalid immediately with no response after reset release.
REQ-024 SHALL resume arbitration on the first rising edge after rst_n returns high.

Verification
REQ-025 Fetch-only: if_req=1, if_addr=0,1,2 on consecutive cycles, mem holds 0x20080005,0x20090007,0x01095020 -> if_gnt=1 each cycle; if_rvalid=1 from cycle 2 with those words in order; stall_if=0.
REQ-026 Loader write then fetch: ld_req=1, ld_we=1, ld_addr=3, ld_wdata=0xDEADBEEF, with if_req=1, if_addr=3 -> cycle 1 ld_gnt=1, mem_we=1, stall_if=1; cycle 2 if_gnt=1; cycle 3 if_rvalid=1, if_rdata=0xDEADBEEF; ld_rvalid stays 0.
REQ-027 Starvation: ld_req=1 and if_req=1 held continuously with STARVE_LIMIT=4 -> ld_gnt cycles 1-4, if_gnt cycle 5, ld_gnt cycles 6-9, if_gnt cycle 10; never both grants.
REQ-028 Loader read: ld_req=1, ld_we=0, ld_addr=0x10, mem[0x10]=0x8C020004, if_req=0 -> ld_gnt=1, next cycle ld_rvalid=1, ld_rdata=0x8C020004; if_rdata unchanged.
REQ-029 Reset mid-operation: fetch granted at cycle N, rst_n=0 asserted between edges N and N+1 -> if_rvalid=0 and if_rdata=0 immediately; starve_cnt=0; after release, first fetch completes with latency 1.
